// File: rtl/bnn_argmax_classifier.sv
// BNN output-stage classifier: collects NUM_CLASSES signed FC scores per
// image into a readable score buffer. It tracks the running argmax, offers
// the winning class over a valid/ready handshake, and flags stream
// protocol errors (overrun, short image).
`timescale 1ns/1ps

module bnn_argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              result_tvalid,
    input  logic [DATA_W-1:0] result_tdata,
    input  logic              cnn_done,
    output logic              class_valid,
    input  logic              class_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_short,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // Count is one bit wider than the index so NUM_CLASSES=16 cannot wrap.
    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(NUM_CLASSES - 1);
    localparam logic [IDX_W:0] NUM_CNT  = (IDX_W+1)'(NUM_CLASSES);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [IDX_W:0]           r_cnt;
    logic signed [DATA_W-1:0] r_max_score;
    logic [IDX_W-1:0]         r_max_idx;
    logic                     r_err_overrun;
    logic                     r_err_short;
    logic [DATA_W-1:0]        r_mem [NUM_CLASSES];
    logic [DATA_W-1:0]        r_rd_data;

    logic w_accept;
    logic w_last_beat;
    logic w_new_max;
    logic w_short;
    logic w_overrun;

    // A start pulse always wins: any beat, done or error in that cycle is dropped.
    assign w_accept    = (r_state == S_COLLECT) && result_tvalid && !start;
    assign w_last_beat = w_accept && (r_cnt == LAST_CNT);
    // Direct signed compare (no subtraction) so extreme values cannot overflow;
    // strict '>' keeps the lower index on ties.
    assign w_new_max   = (r_cnt == '0) || ($signed(result_tdata) > r_max_score);
    // A final beat coinciding with cnn_done completes the image normally.
    assign w_short     = (r_state == S_COLLECT) && cnn_done && !start && !w_last_beat;
    assign w_overrun   = (r_state == S_HOLD) && result_tvalid && !start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (start)            w_next_state = S_COLLECT;
                else if (w_last_beat) w_next_state = S_HOLD;
                else if (w_short)     w_next_state = S_IDLE;
            end
            S_HOLD: begin
                if (start)            w_next_state = S_COLLECT;
                else if (class_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Beat counter, running argmax and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_max_score   <= '0;
            r_max_idx     <= '0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
        end else if (start) begin
            r_cnt         <= '0;
            r_max_score   <= '0;
            r_max_idx     <= '0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + (IDX_W+1)'(1);
                if (w_new_max) begin
                    r_max_score <= $signed(result_tdata);
                    r_max_idx   <= r_cnt[IDX_W-1:0];
                end
            end
            if (w_overrun) r_err_overrun <= 1'b1;
            if (w_short)   r_err_short   <= 1'b1;
        end
    end

    // Score buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset so it can map onto RAM; entries are
        // always written before an image's class is presented.
        if (w_accept) r_mem[r_cnt[IDX_W-1:0]] <= result_tdata;
    end

    // Registered read port; out-of-range addresses read as zero, and a read
    // colliding with a write returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_rd_data <= '0;
        else if ({1'b0, rd_addr} < NUM_CNT) r_rd_data <= r_mem[rd_addr];
        else                               r_rd_data <= '0;
    end

    assign class_valid = (r_state == S_HOLD);
    assign busy        = (r_state == S_COLLECT);
    assign class_idx   = r_max_idx;
    assign class_score = r_max_score;
    assign err_overrun = r_err_overrun;
    assign err_short   = r_err_short;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_bnn_argmax_classifier.sv
// Self-checking bench for bnn_argmax_classifier: table vectors, directed
// corner sequences and randomized images against an argmax reference model.
`timescale 1ns/1ps

module tb_bnn_argmax_classifier;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          result_tvalid = 1'b0;
    logic [DW-1:0] result_tdata = '0;
    logic          cnn_done = 1'b0;
    logic          class_valid;
    logic          class_ready = 1'b0;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] class_score;
    logic          busy;
    logic          err_overrun;
    logic          err_short;
    logic [IW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;

    int total = 0;
    int bad   = 0;

    bnn_argmax_classifier #(.NUM_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .result_tvalid(result_tvalid), .result_tdata(result_tdata),
        .cnn_done(cnn_done), .class_valid(class_valid), .class_ready(class_ready),
        .class_idx(class_idx), .class_score(class_score), .busy(busy),
        .err_overrun(err_overrun), .err_short(err_short),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef logic [N-1:0][DW-1:0] image_t;

    typedef struct {
        image_t        s;
        int            gap;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] e_score;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        result_tvalid = 1'b1;
        result_tdata  = d;
        tick();
        result_tvalid = 1'b0;
    endtask

    task automatic send_image(input image_t s, input int gap);
        for (int i = 0; i < N; i++) begin
            send_beat(s[i]);
            if (i < N - 1) repeat (gap) tick();
        end
    endtask

    task automatic handshake();
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
    endtask

    task automatic read_check(input string name, input int addr, input logic [DW-1:0] exp);
        rd_addr = IW'(addr);
        tick();
        check(name, rd_data, exp);
    endtask

    // Reference: first index holding the largest signed score.
    function automatic int ref_argmax(input image_t s);
        int best = 0;
        for (int i = 1; i < N; i++)
            if ($signed(s[i]) > $signed(s[best])) best = i;
        return best;
    endfunction

    function automatic image_t ramp(input int base, input int step);
        image_t s;
        for (int i = 0; i < N; i++) s[i] = DW'(base + step * i);
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t   vecs [6];
        image_t img;
        int     tbl [6][N];
        int     gaps [6]     = '{0, 3, 1, 0, 2, 0};
        int     e_idx [6]    = '{2, 9, 9, 0, 0, 5};
        int     e_score [6];
        int     exp_i;
        int     addr;
        int     mode;

        tbl[0] = '{5, -3, 7, 2, 7, 0, -100, 6, 1, -1};
        tbl[1] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000001};
        tbl[2] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[3] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        tbl[4] = '{-4, -4, -4, -4, -4, -4, -4, -4, -4, -4};
        tbl[5] = '{-10, -20, -30, -40, -50, 32'h7fffffff, -60, 32'h7fffffff, -70, -80};
        e_score = '{7, 32'h80000001, 9, 9, -4, 32'h7fffffff};
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) vecs[r].s[i] = tbl[r][i];
            vecs[r].gap     = gaps[r];
            vecs[r].e_idx   = IW'(e_idx[r]);
            vecs[r].e_score = e_score[r];
        end

        // Reset state
        #12;
        check("rst_class_valid", DW'(class_valid), 0);
        check("rst_busy", DW'(busy), 0);
        check("rst_class_score", class_score, 0);
        check("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Table vectors, including the back-to-back tie image and the
        // most-negative image with 3-cycle gaps.
        for (int r = 0; r < 6; r++) begin
            pulse_start();
            check($sformatf("v%0d_busy", r), DW'(busy), 1);
            send_image(vecs[r].s, vecs[r].gap);
            check($sformatf("v%0d_valid", r), DW'(class_valid), 1);
            check($sformatf("v%0d_idx", r), DW'(class_idx), DW'(vecs[r].e_idx));
            check($sformatf("v%0d_score", r), class_score, vecs[r].e_score);
            handshake();
            check($sformatf("v%0d_valid_drop", r), DW'(class_valid), 0);
            if (r == 0) read_check("v0_rd6", 6, -100);
        end
        read_check("rd_out_of_range", 12, 0);

        // Short image: cnn_done after 4 beats
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat(DW'(i));
        cnn_done = 1'b1; tick(); cnn_done = 1'b0;
        check("short_err", DW'(err_short), 1);
        check("short_valid", DW'(class_valid), 0);
        check("short_busy", DW'(busy), 0);
        pulse_start();
        check("short_cleared", DW'(err_short), 0);
        send_image(ramp(0, 1), 0);
        check("short_recover_idx", DW'(class_idx), 9);
        handshake();

        // Overrun while holding, class_ready low for 20 cycles
        pulse_start();
        send_image(vecs[0].s, 0);
        for (int c = 0; c < 20; c++) begin
            if (c == 5 || c == 12) send_beat(1000);
            else tick();
        end
        check("ovr_err", DW'(err_overrun), 1);
        check("ovr_valid", DW'(class_valid), 1);
        check("ovr_idx", DW'(class_idx), 2);
        check("ovr_score", class_score, 7);
        read_check("ovr_buf0", 0, 5);
        handshake();
        check("ovr_sticky", DW'(err_overrun), 1);
        pulse_start();
        check("ovr_cleared", DW'(err_overrun), 0);

        // Restart mid-image (already in COLLECT from above)
        for (int i = 0; i < 6; i++) send_beat(100 + i);
        pulse_start();
        send_image(ramp(0, 1), 0);
        check("restart_idx", DW'(class_idx), 9);
        check("restart_score", class_score, 9);
        check("restart_errs", DW'({err_overrun, err_short}), 0);
        read_check("restart_buf0", 0, 0);
        handshake();

        // cnn_done coincident with the final beat: the beat wins
        pulse_start();
        img = ramp(20, -1);
        for (int i = 0; i < N - 1; i++) send_beat(img[i]);
        cnn_done = 1'b1;
        send_beat(img[N-1]);
        cnn_done = 1'b0;
        check("done_last_valid", DW'(class_valid), 1);
        check("done_last_err", DW'(err_short), 0);
        check("done_last_idx", DW'(class_idx), 0);

        // start in HOLD abandons the class even with class_ready high
        class_ready = 1'b1;
        pulse_start();
        class_ready = 1'b0;
        check("hold_start_valid", DW'(class_valid), 0);
        check("hold_start_busy", DW'(busy), 1);
        send_image(ramp(-5, 2), 1);
        check("hold_start_idx", DW'(class_idx), 9);
        handshake();

        // Asynchronous reset during beat 5, then beats without start ignored
        pulse_start();
        for (int i = 0; i < 5; i++) send_beat(DW'(i + 1));
        rd_addr = 3;
        result_tvalid = 1'b1;
        result_tdata  = 77;
        #3 rst = 1'b1;
        #1;
        check("arst_busy", DW'(busy), 0);
        check("arst_score", class_score, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_flags", DW'({class_valid, err_overrun, err_short, class_idx}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        result_tvalid = 1'b0;
        for (int i = 0; i < N; i++) send_beat(50);
        check("post_rst_busy", DW'(busy), 0);
        check("post_rst_valid", DW'(class_valid), 0);
        check("post_rst_ovr", DW'(err_overrun), 0);

        // Beat alongside start is dropped
        result_tvalid = 1'b1;
        result_tdata  = 1000;
        pulse_start();
        result_tvalid = 1'b0;
        send_image(ramp(0, 1), 0);
        check("start_beat_idx", DW'(class_idx), 9);
        check("start_beat_score", class_score, 9);
        handshake();

        // Randomized images against the reference model
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < N; i++) begin
                mode = $urandom_range(0, 2);
                if (mode == 0)      img[i] = DW'($urandom_range(0, 6)) - 3;
                else if (mode == 1) img[i] = $urandom;
                else begin
                    case ($urandom_range(0, 3))
                        0:       img[i] = 32'h80000000;
                        1:       img[i] = 32'h7fffffff;
                        2:       img[i] = 32'hffffffff;
                        default: img[i] = 0;
                    endcase
                end
            end
            exp_i = ref_argmax(img);
            pulse_start();
            for (int i = 0; i < N; i++) begin
                send_beat(img[i]);
                if (i < N - 1) repeat ($urandom_range(0, 2)) tick();
            end
            check($sformatf("rnd%0d_valid", k), DW'(class_valid), 1);
            check($sformatf("rnd%0d_idx", k), DW'(class_idx), DW'(exp_i));
            check($sformatf("rnd%0d_score", k), class_score, img[exp_i]);
            repeat ($urandom_range(0, 3)) tick();
            check($sformatf("rnd%0d_held", k), DW'(class_valid), 1);
            handshake();
            check($sformatf("rnd%0d_drop", k), DW'(class_valid), 0);
            addr = $urandom_range(0, 15);
            read_check($sformatf("rnd%0d_rd%0d", k, addr), addr, (addr < N) ? img[addr] : '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
